// File: rtl/dpram_pkg.sv
// Shared types for the byte-enable dual-port RAM with clear.
// Holds the FSM state type and the legal read latencies.
package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dp_state_e;

  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read pipeline: one or two register stages.
// Data is forced to zero whenever the valid bit is low.
module dpram_rd_pipe
  import dpram_pkg::*;
#(
  parameter int DW  = 32,
  parameter int LAT = RD_LAT_1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] q,
  output logic          qv
);

  logic          v1_q, v1_d;
  logic [DW-1:0] d1_q, d1_d;

  always_comb begin
    v1_d = in_valid;
    d1_d = in_valid ? in_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
    end
  end

  if (LAT == RD_LAT_2) begin : g_lat2
    logic          v2_q, v2_d;
    logic [DW-1:0] d2_q, d2_d;

    always_comb begin
      v2_d = v1_q;
      d2_d = d1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end

    assign q  = d2_q;
    assign qv = v2_q;
  end else begin : g_lat1
    assign q  = d1_q;
    assign qv = v1_q;
  end

endmodule

// File: rtl/dpram_be_clr.sv
// Dual-port RAM with byte enables, self-clear after reset/CLR,
// port-A write priority, optional write-to-read bypass.
module dpram_be_clr
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter     RAM_STYLE_VAL = "block",
  parameter int READ_LATENCY  = RD_LAT_1,
  parameter int BYPASS        = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CLR,
  input  logic                       CENA,
  input  logic                       CENB,
  input  logic                       WENA,
  input  logic                       WENB,
  input  logic [DATA_WIDTH/8-1:0]    BEA,
  input  logic [DATA_WIDTH/8-1:0]    BEB,
  input  logic [$clog2(DEPTH)-1:0]   AA,
  input  logic [$clog2(DEPTH)-1:0]   AB,
  input  logic [DATA_WIDTH-1:0]      DA,
  input  logic [DATA_WIDTH-1:0]      DB,
  output logic [DATA_WIDTH-1:0]      QA,
  output logic [DATA_WIDTH-1:0]      QB,
  output logic                       QVA,
  output logic                       QVB,
  output logic                       READY,
  output logic                       COLL
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  (* ram_style = RAM_STYLE_VAL *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  dp_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            coll_q, coll_d;

  logic            run;
  logic            we_a, we_b;
  logic            re_a, re_b;
  logic            clr_we;
  logic [DATA_WIDTH-1:0] rdat_a, rdat_b;

  assign run    = (state_q == RUN);
  assign we_a   = run & ~CENA & ~WENA;
  assign we_b   = run & ~CENB & ~WENB;
  assign re_a   = run & ~CENA & WENA;
  assign re_b   = run & ~CENB & WENB;
  assign clr_we = ~run & RST_N;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coll_d  = run & ~CENA & ~CENB & (AA == AB)
            & (~WENA | ~WENB);
    unique case (1'b1)
      (state_q == CLEAR): begin
        if (CLR) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      (state_q == RUN): begin
        if (CLR) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
    end
  end

  // B first, then A, so A wins any byte both ports enable.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (we_b && BEB[i])
          mem[AB][i*8 +: 8] <= DB[i*8 +: 8];
        if (we_a && BEA[i])
          mem[AA][i*8 +: 8] <= DA[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rdat_a = mem[AA];
    rdat_b = mem[AB];
    if (BYPASS != 0 && AA == AB) begin
      for (int i = 0; i < NB; i++) begin
        if (we_b && BEB[i])
          rdat_a[i*8 +: 8] = DB[i*8 +: 8];
        if (we_a && BEA[i])
          rdat_b[i*8 +: 8] = DA[i*8 +: 8];
      end
    end
  end

  dpram_rd_pipe #(
    .DW  (DATA_WIDTH),
    .LAT (READ_LATENCY)
  ) u_pipe_a (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_valid (re_a),
    .in_data  (rdat_a),
    .q        (QA),
    .qv       (QVA)
  );

  dpram_rd_pipe #(
    .DW  (DATA_WIDTH),
    .LAT (READ_LATENCY)
  ) u_pipe_b (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_valid (re_b),
    .in_data  (rdat_b),
    .q        (QB),
    .qv       (QVB)
  );

  assign READY = run;
  assign COLL  = coll_q;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances (lat1/no-bypass, lat2/bypass)
// share stimulus; a memory-level model is checked every cycle.
module tb_dpram_be_clr;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        cena = 1'b1, cenb = 1'b1;
  logic        wena = 1'b1, wenb = 1'b1;
  logic [3:0]  bea = '0, beb = '0;
  logic [3:0]  aa = '0, ab = '0;
  logic [31:0] da = '0, db = '0;

  logic [31:0] qa0, qb0, qa1, qb1;
  logic        qva0, qvb0, qva1, qvb1;
  logic        ready0, ready1, coll0, coll1;

  int nv = 0;
  int nf = 0;

  always #5 clk = ~clk;

  dpram_be_clr #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .RAM_STYLE_VAL("block"),
    .READ_LATENCY(1), .BYPASS(0)
  ) u0 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .CENA(cena), .CENB(cenb), .WENA(wena), .WENB(wenb),
    .BEA(bea), .BEB(beb), .AA(aa), .AB(ab), .DA(da), .DB(db),
    .QA(qa0), .QB(qb0), .QVA(qva0), .QVB(qvb0),
    .READY(ready0), .COLL(coll0)
  );

  dpram_be_clr #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .RAM_STYLE_VAL("block"),
    .READ_LATENCY(2), .BYPASS(1)
  ) u1 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .CENA(cena), .CENB(cenb), .WENA(wena), .WENB(wenb),
    .BEA(bea), .BEB(beb), .AA(aa), .AB(ab), .DA(da), .DB(db),
    .QA(qa1), .QB(qb1), .QVA(qva1), .QVB(qvb1),
    .READY(ready1), .COLL(coll1)
  );

  // Model: memory contents, clear cycles left, per-request results.
  logic [31:0] mm [DEPTH];
  int          clr_left;
  logic        coll_e;
  logic [31:0] s1d [2][2];
  logic [31:0] s2d [2][2];
  logic        s1v [2][2];
  logic        s2v [2][2];
  logic        m_run, m_wa, m_wb, m_ra, m_rb;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left = DEPTH;
      coll_e   = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          s1d[k][p] = '0; s1v[k][p] = 1'b0;
          s2d[k][p] = '0; s2v[k][p] = 1'b0;
        end
    end else begin
      m_run = (clr_left == 0);
      m_wa  = m_run && !cena && !wena;
      m_wb  = m_run && !cenb && !wenb;
      m_ra  = m_run && !cena && wena;
      m_rb  = m_run && !cenb && wenb;
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          s2d[k][p] = s1d[k][p];
          s2v[k][p] = s1v[k][p];
        end
        s1v[k][0] = m_ra;
        s1d[k][0] = !m_ra ? 32'h0 :
                    (k == 1 && m_wb && aa == ab) ?
                    merge(mm[aa], db, beb) : mm[aa];
        s1v[k][1] = m_rb;
        s1d[k][1] = !m_rb ? 32'h0 :
                    (k == 1 && m_wa && aa == ab) ?
                    merge(mm[ab], da, bea) : mm[ab];
      end
      coll_e = m_run && !cena && !cenb && aa == ab
             && (m_wa || m_wb);
      if (m_run) begin
        if (m_wb) mm[ab] = merge(mm[ab], db, beb);
        if (m_wa) mm[aa] = merge(mm[aa], da, bea);
        if (clr) clr_left = DEPTH;
      end else begin
        mm[DEPTH - clr_left] = '0;
        if (clr) clr_left = DEPTH;
        else     clr_left = clr_left - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nv++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("u0.QA",    qa0,    s1d[0][0]);
    chk("u0.QVA",   qva0,   s1v[0][0]);
    chk("u0.QB",    qb0,    s1d[0][1]);
    chk("u0.QVB",   qvb0,   s1v[0][1]);
    chk("u1.QA",    qa1,    s2d[1][0]);
    chk("u1.QVA",   qva1,   s2v[1][0]);
    chk("u1.QB",    qb1,    s2d[1][1]);
    chk("u1.QVB",   qvb1,   s2v[1][1]);
    chk("u0.COLL",  coll0,  coll_e);
    chk("u1.COLL",  coll1,  coll_e);
    chk("u0.READY", ready0, clr_left == 0);
    chk("u1.READY", ready1, clr_left == 0);
  end

  task automatic pa(input logic w, input logic [3:0] be,
                    input logic [3:0] a, input logic [31:0] d);
    cena = 1'b0; wena = w; bea = be; aa = a; da = d;
  endtask

  task automatic pb(input logic w, input logic [3:0] be,
                    input logic [3:0] a, input logic [31:0] d);
    cenb = 1'b0; wenb = w; beb = be; ab = a; db = d;
  endtask

  task automatic tick(input logic c);
    clr = c;
    @(negedge clk);
    cena = 1'b1; cenb = 1'b1;
    wena = 1'b1; wenb = 1'b1;
    clr  = 1'b0;
  endtask

  task automatic wait_clear(input string nm);
    repeat (15) tick(1'b0);
    chk({nm, "_ready15"}, ready0, 1'b0);
    tick(1'b0);
    chk({nm, "_ready16"}, ready0, 1'b1);
    chk({nm, "_ready16_u1"}, ready1, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_qva",   qva0,   1'b0);
    rst_n = 1'b1;
    wait_clear("init");

    for (int a = 0; a < DEPTH; a++) begin
      pa(1'b1, 4'h0, 4'(a), 32'h0);
      pb(1'b1, 4'h0, 4'(15 - a), 32'h0);
      tick(1'b0);
    end

    pa(1'b0, 4'hF, 4'h3, 32'h11223344); tick(1'b0);
    pa(1'b0, 4'h5, 4'h3, 32'hAABBCCDD); tick(1'b0);
    pa(1'b1, 4'h0, 4'h3, 32'h0);        tick(1'b0);
    chk("be_u0",       qa0,  32'h11BB33DD);
    chk("be_qv_u0",    qva0, 1'b1);
    chk("be_qv_u1_l1", qva1, 1'b0);
    tick(1'b0);
    chk("be_u1",       qa1,  32'h11BB33DD);
    chk("be_qv_u1",    qva1, 1'b1);

    pa(1'b0, 4'hF, 4'h5, 32'h1);
    pb(1'b0, 4'hF, 4'h5, 32'h2);
    tick(1'b0);
    chk("coll_ww", coll0, 1'b1);
    pa(1'b1, 4'h0, 4'h5, 32'h0); tick(1'b0);
    chk("coll_once", coll0, 1'b0);
    chk("prio_rd",   qa0,   32'h1);

    pa(1'b0, 4'h3, 4'h9, 32'hAAAAAAAA);
    pb(1'b0, 4'h6, 4'h9, 32'hBBBBBBBB);
    tick(1'b0);
    pa(1'b1, 4'h0, 4'h9, 32'h0); tick(1'b0);
    chk("byte_prio", qa0, 32'h00BBAAAA);

    pa(1'b0, 4'hF, 4'h7, 32'hFFFFFFFF);
    pb(1'b1, 4'h0, 4'h7, 32'h0);
    tick(1'b0);
    chk("rw_nobyp", qb0,   32'h0);
    chk("rw_coll",  coll0, 1'b1);
    chk("rw_coll1", coll1, 1'b1);
    tick(1'b0);
    chk("rw_byp",   qb1,   32'hFFFFFFFF);

    pb(1'b0, 4'hC, 4'h8, 32'h12345678);
    pa(1'b1, 4'h0, 4'h8, 32'h0);
    tick(1'b0);
    chk("wr_nobyp", qa0, 32'h0);
    tick(1'b0);
    chk("wr_byp",   qa1, 32'h12340000);

    for (int i = 0; i < 40; i++) begin
      pa(1'((i % 3) != 0), 4'(i * 7), 4'(i * 5),
         32'(i) * 32'h01030507);
      pb(1'((i % 4) != 1), 4'(~i), 4'(i * 3),
         32'(i) * 32'h0B0D1113);
      tick(1'b0);
    end
    tick(1'b0);
    tick(1'b0);

    pa(1'b0, 4'hF, 4'h4, 32'hCAFEF00D); tick(1'b0);
    pa(1'b1, 4'h0, 4'h4, 32'h0);        tick(1'b1);
    chk("clr_ready",  ready0, 1'b0);
    chk("clr_rd_u0",  qa0,    32'hCAFEF00D);
    pa(1'b1, 4'h0, 4'h4, 32'h0);        tick(1'b0);
    chk("clr_rd_u1",  qa1,    32'hCAFEF00D);
    chk("clr_noqv",   qva0,   1'b0);
    tick(1'b0);
    chk("clr_noqv_u1", qva1, 1'b0);
    repeat (3) tick(1'b0);
    tick(1'b1);
    wait_clear("restart");
    pa(1'b1, 4'h0, 4'h4, 32'h0); tick(1'b0);
    chk("cleared",    qa0,  32'h0);
    chk("cleared_qv", qva0, 1'b1);

    pa(1'b1, 4'h0, 4'h3, 32'h0); tick(1'b1);
    chk("pre_rst_qv", qva0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_qva",   qva0,   1'b0);
    chk("rst_qa",    qa0,    32'h0);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_qva1",  qva1,   1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("rerst");
    tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end

endmodule

// File: doc/dpram_be_clr.md
DPRAM_BE_CLR -- requirements
Module: dpram_be_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024: words; address width $clog2(DEPTH).
REQ-003 SHALL have parameter RAM_STYLE_VAL, default "block": ram_style attribute on the array.
REQ-004 SHALL have parameter READ_LATENCY, default 1: legal values 1 or 2 cycles.
REQ-005 SHALL have parameter BYPASS, default 0: when 1, a cross-port same-address read returns the same-cycle write data.
REQ-006 SHALL have one clock and reset. Reset is asynchronous and active-low. Ports: CLK input 1 (all logic); RST_N input 1 (reset).
REQ-007 SHALL have CLR input 1: synchronous pulse that restarts the memory clear.
REQ-008 SHALL have CENA and CENB input 1: active-low port enables.
REQ-009 SHALL have WENA and WENB input 1: 0 = write, 1 = read.
REQ-010 SHALL have BEA and BEB input DATA_WIDTH/8: active-high byte write enables.
REQ-011 SHALL have AA and AB input $clog2(DEPTH): addresses.
REQ-012 SHALL have DA and DB input DATA_WIDTH: write data.
REQ-013 SHALL have QA and QB output DATA_WIDTH: read data; 0 when not valid.
REQ-014 SHALL have QVA and QVB output 1: read-data valid strobes.
REQ-015 SHALL have READY output 1: high when the clear is complete and accesses are accepted.
REQ-016 SHALL have COLL output 1: one-cycle same-address collision flag.

Function
REQ-017 SHALL run an FSM with states CLEAR and RUN. Reset enters CLEAR; CLEAR goes to RUN after DEPTH cycles; RUN goes to CLEAR on CLR=1.
REQ-018 In CLEAR, SHALL write 0 to address cnt each cycle, with cnt counting 0..DEPTH-1; READY=0; all port accesses are ignored (no write, no QV).
REQ-019 CLR asserted during CLEAR SHALL restart cnt at 0.
REQ-020 In RUN, SHALL perform a port write when CEN=0 and WEN=0. Only bytes with BE=1 update; BE=0 is a no-op.
REQ-021 In RUN, SHALL perform a port read when CEN=0 and WEN=1. Data SHALL appear on Q with QV=1 exactly READY_LATENCY... exactly READ_LATENCY rising edges after the request.
REQ-022 Otherwise, Q=0 and QV=0 in the matching output cycle. Each port pipeline is independent and fully pipelined, one request per cycle.
REQ-023 When both ports write the same address in the same cycle, SHALL give port A priority per byte where both BE=1, and write B's bytes where only BEB=1.
REQ-024 On a same-cycle cross-port read/write to the same address, the read SHALL return old contents if BYPASS=0. If BYPASS=1, it SHALL return old contents merged with the writer's enabled bytes.
REQ-025 COLL SHALL be 1 in the cycle after any RUN cycle where CENA=CENB=0, AA==AB, and at least one port writes; otherwise COLL=0.
REQ-026 CLR arriving in RUN SHALL take effect next cycle. Reads in flight SHALL still complete with pre-clear data.

Reset
REQ-027 While RST_N=0, SHALL hold QA=QB=0, QVA=QVB=0, COLL=0, READY=0, the FSM in CLEAR, cnt=0, and the pipeline valids at 0. Array contents are untouched by reset itself.
REQ-028 Release of RST_N SHALL start the clear on the first CLK edge.

Structure
REQ-029 Package dpram_pkg SHALL hold the FSM state typedef (CLEAR, RUN) and the legal READ_LATENCY constants.
REQ-030 Sub-module dpram_rd_pipe, instantiated once per port, SHALL hold the latency-1/2 data and valid registers, with async reset.

Verification
REQ-031 DEPTH=16, reset release: READY rises after 16 cycles; then every address reads 0.
REQ-032 RUN, A writes 0xAABBCCDD with BEA=4'b0101 to 0x3 (prior 0x11223344): A read of 0x3 returns 0x11BB33DD; QVA is 1 at latency 1, and at latency 2 when READ_LATENCY=2.
REQ-033 Same cycle, A writes 0x1 with BEA=4'hF and B writes 0x2 with BEB=4'hF to address 5: the read returns 0x1 and COLL pulses once.
REQ-034 Same cycle, A writes 0xFFFFFFFF to 7 (old 0) and B reads 7: QB=0 with BYPASS=0 and QB=0xFFFFFFFF with BYPASS=1; COLL=1.
REQ-035 CLR pulse in RUN with a read in flight: the read completes with old data, READY drops next cycle, and accesses during CLEAR produce QV=0.
REQ-036 RST_N asserted mid-CLEAR: outputs go to 0 immediately, and the clear restarts from cnt=0 after release.
